// File: rtl/fw_clkgen_pkg.sv
// Shared types and helpers for the multi-channel bunch-crossing clock generator.
package fw_clkgen_pkg;

   // Field width of the per-channel config struct; the top-level PERIOD_W follows it.
   localparam int CFG_PERIOD_W = 8;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2
   } state_t;

   typedef struct packed {
      logic                    sign;
      logic [CFG_PERIOD_W-1:0] high;
      logic [CFG_PERIOD_W-1:0] delay;
   } ch_cfg_t;

   function automatic logic [CFG_PERIOD_W-1:0] clamp_period(input logic [CFG_PERIOD_W-1:0] p);
      return (p < CFG_PERIOD_W'(2)) ? CFG_PERIOD_W'(2) : p;
   endfunction

   // High time needs no clamp: the phase is always below P, so h >= P is constant high.
   function automatic ch_cfg_t clamp_ch(input ch_cfg_t c, input logic [CFG_PERIOD_W-1:0] p);
      ch_cfg_t r;
      r = c;
      if (c.delay >= p) r.delay = p - 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fw_clkgen_phase_ch.sv
// One output channel: phase of the shared counter against delay/high time, registered.
module fw_clkgen_phase_ch
   import fw_clkgen_pkg::*;
#(
   parameter int PERIOD_W = CFG_PERIOD_W
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                active,
   input  logic [PERIOD_W-1:0] cnt,
   input  logic [PERIOD_W-1:0] period,
   input  ch_cfg_t             cfg,
   output logic                clk_out
);

   logic [PERIOD_W:0] diff;
   logic [PERIOD_W:0] ph;
   logic              level;
   logic              clk_out_reg;

   always_comb begin
      diff  = {1'b0, cnt} - {1'b0, cfg.delay};
      ph    = diff[PERIOD_W] ? (diff + {1'b0, period}) : diff;
      level = (ph < {1'b0, cfg.high}) ^ cfg.sign;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_out_reg <= 1'b0;
      else        clk_out_reg <= active & level;
   end

   assign clk_out = clk_out_reg;

endmodule

// File: rtl/fw_bxclk_gen_multi.sv
// Multi-channel bunch-crossing clock generator: shared period counter, run/burst FSM,
// double-buffered config applied on period boundaries, registered readback.
module fw_bxclk_gen_multi
   import fw_clkgen_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int PERIOD_W   = CFG_PERIOD_W,
   parameter int BURST_W    = 16,
   parameter int RST_PERIOD = 10,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                fw_pl_clk1,
   input  logic                fw_rst_n,
   input  logic                enable,
   input  logic                run_mode,
   input  logic                burst_start,
   input  logic [BURST_W-1:0]  burst_len,
   input  logic                cfg_period_we,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_ch_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [PERIOD_W-1:0] cfg_delay,
   input  logic [PERIOD_W-1:0] cfg_high,
   input  logic                cfg_sign,
   input  logic                cfg_commit,
   output logic [NUM_CH-1:0]   clk_out,
   output logic                cycle_strobe,
   output logic                busy,
   output logic                burst_done,
   output logic                cfg_pending,
   output logic [31:0]         cfg_rdata
);

   localparam logic [PERIOD_W-1:0] RST_P  = PERIOD_W'(RST_PERIOD);
   localparam ch_cfg_t             RST_CH = '{sign: 1'b0, high: PERIOD_W'(RST_PERIOD / 2), delay: '0};

   state_t              state_reg, state_next;
   logic [PERIOD_W-1:0] cnt_reg, cnt_next;
   logic [PERIOD_W-1:0] period_reg, shadow_period_reg, shadow_period_next, period_new;
   ch_cfg_t             active_ch_reg [NUM_CH];
   ch_cfg_t             shadow_ch_reg [NUM_CH];
   ch_cfg_t             shadow_ch_next[NUM_CH];
   logic                pending_reg, pending_next;
   logic [BURST_W-1:0]  burst_cnt_reg, burst_cnt_next;
   logic                burst_done_reg, burst_done_next;
   logic [31:0]         rdata_reg, rdata_next;
   logic [31:0]         ch_idx;
   logic                running, strobe, apply, gen_active;

   assign ch_idx     = 32'(cfg_ch);
   assign running    = (state_reg != IDLE);
   assign strobe     = running && (cnt_reg == period_reg - 1'b1);
   assign gen_active = running && enable;

   // Busy: wait for a boundary strictly after the commit cycle. Idle: apply on the next edge.
   assign apply        = running ? (pending_reg && strobe) : (cfg_commit || pending_reg);
   assign pending_next = (pending_reg && !apply) || (cfg_commit && running);

   assign shadow_period_next = cfg_period_we ? cfg_period : shadow_period_reg;
   assign period_new         = clamp_period(shadow_period_next);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         shadow_ch_next[i] = shadow_ch_reg[i];
         if (cfg_ch_we && (ch_idx == 32'(i)))
            shadow_ch_next[i] = '{sign: cfg_sign, high: cfg_high, delay: cfg_delay};
      end
   end

   always_comb begin
      state_next      = state_reg;
      burst_cnt_next  = burst_cnt_reg;
      burst_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable) begin
               if (run_mode == MODE_CONT) begin
                  state_next = RUN;
               end else if (burst_start) begin
                  if (burst_len != '0) begin
                     state_next     = BURST;
                     burst_cnt_next = burst_len;
                  end else begin
                     burst_done_next = 1'b1;
                  end
               end
            end
         end
         RUN: begin
            if (!enable || (run_mode == MODE_BURST)) state_next = IDLE;
         end
         BURST: begin
            if (!enable) begin
               state_next = IDLE;
            end else if (strobe) begin
               burst_cnt_next = burst_cnt_reg - 1'b1;
               if (burst_cnt_reg == BURST_W'(1)) begin
                  state_next      = IDLE;
                  burst_done_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The counter holds at 0 while idle, so the first running tick is always cnt=0.
   assign cnt_next = ((state_reg == IDLE) || (state_next == IDLE) || strobe) ? '0 : cnt_reg + 1'b1;

   always_comb begin
      rdata_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == 32'(i)) rdata_next = 32'({active_ch_reg[i], period_reg});
      end
   end

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         state_reg         <= IDLE;
         cnt_reg           <= '0;
         period_reg        <= RST_P;
         shadow_period_reg <= RST_P;
         pending_reg       <= 1'b0;
         burst_cnt_reg     <= '0;
         burst_done_reg    <= 1'b0;
         rdata_reg         <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_ch_reg[i] <= RST_CH;
            active_ch_reg[i] <= RST_CH;
         end
      end else begin
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         shadow_period_reg <= shadow_period_next;
         pending_reg       <= pending_next;
         burst_cnt_reg     <= burst_cnt_next;
         burst_done_reg    <= burst_done_next;
         rdata_reg         <= rdata_next;
         if (apply) period_reg <= period_new;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_ch_reg[i] <= shadow_ch_next[i];
            if (apply) active_ch_reg[i] <= clamp_ch(shadow_ch_next[i], period_new);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
         fw_clkgen_phase_ch #(.PERIOD_W(PERIOD_W)) u_phase (
            .clk     (fw_pl_clk1),
            .rst_n   (fw_rst_n),
            .active  (gen_active),
            .cnt     (cnt_reg),
            .period  (period_reg),
            .cfg     (active_ch_reg[gi]),
            .clk_out (clk_out[gi])
         );
      end
   endgenerate

   assign cycle_strobe = strobe;
   assign busy         = running;
   assign burst_done   = burst_done_reg;
   assign cfg_pending  = pending_reg;
   assign cfg_rdata    = rdata_reg;

endmodule

// File: doc/fw_bxclk_gen_multi.md
# fw_bxclk_gen_multi

Multi-channel programmable bunch-crossing clock generator for the pixel test firmware, running in the 400 MHz fw_pl_clk1 domain. It is the parametrised successor to the fixed two-output bxclk_ana/bxclk generator. It drives NUM_CH phase-related clocks from one shared period counter, with per-channel delay, polarity and high time, and a continuous or counted-burst run mode. Configuration is double-buffered and applied only on period boundaries, so outputs never glitch. Register-bus decode and CDC from the AXI domain sit upstream.

## Interface
- NUM_CH, 2: output channels; channel 0 is the analog reference (bxclk_ana role).
- PERIOD_W, 8: width of period, delay and high-time fields.
- BURST_W, 16: width of burst length and burst counter.
- RST_PERIOD, 10: period in ticks after reset (40 MHz at 400 MHz).
- CH_W, derived: max(1, $clog2(NUM_CH)).

Ports:
- fw_pl_clk1  in  1  clock, 400 MHz.
- fw_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- enable  in  1  run gate (fw_dev_id_enable level).
- run_mode  in  1  0 = continuous, 1 = burst.
- burst_start  in  1  one-cycle pulse; starts a burst when run_mode=1.
- burst_len  in  BURST_W  number of periods per burst.
- cfg_period_we  in  1  write shadow period.
- cfg_period  in  PERIOD_W  period in ticks.
- cfg_ch_we  in  1  write shadow fields of channel cfg_ch.
- cfg_ch  in  CH_W  channel index; out-of-range writes are ignored.
- cfg_delay  in  PERIOD_W  channel delay in ticks.
- cfg_high  in  PERIOD_W  channel high time in ticks.
- cfg_sign  in  1  channel polarity invert.
- cfg_commit  in  1  request transfer of shadow to active config.
- clk_out  out  NUM_CH  generated clocks.
- cycle_strobe  out  1  one-cycle pulse in the tick where the counter is at P-1 (last tick of each period).
- busy  out  1  generator running.
- burst_done  out  1  one-cycle pulse at burst completion.
- cfg_pending  out  1  commit requested, not yet applied.
- cfg_rdata  out  32  {sign, high, delay, period} of active cfg_ch, zero-padded; registered.

## Operation
- Counter cnt runs 0..P-1 while busy and wraps to 0. P is the active period.
- Per channel: ph = (cnt - d) mod P, computed in PERIOD_W+1 bits. clk_out[i] = (ph < h) XOR sign.
- sign=0: the rising edge follows the ch0 rising edge by d ticks. sign=1: the falling edge follows it by d ticks.
- Clamping is applied at commit time:
  - P < 2 becomes 2.
  - d >= P becomes P-1.
  - h = 0 gives a constant low (before sign); h >= P gives a constant high.
- Reset values:
  - Active and shadow config: P = RST_PERIOD, d = 0, h = RST_PERIOD/2, sign = 0.
  - cnt = 0; all outputs 0.
- States: IDLE, RUN, BURST.
  - IDLE→RUN: enable=1 and run_mode=0.
  - IDLE→BURST: enable=1, run_mode=1, burst_start=1 and burst_len ≠ 0. burst_len = 0 produces only a burst_done pulse on the next cycle.
  - BURST→IDLE: after burst_len full periods. burst_done pulses in the cycle after the final cycle_strobe.
  - Any state→IDLE: enable=0. cnt clears and clk_out forces 0 on the next edge. An aborted burst gives no burst_done.
  - RUN→IDLE: run_mode changes to 1. BURST ignores run_mode changes and burst_start.
- Commit behaviour:
  - While busy, commit sets cfg_pending. The shadow is copied at the next cycle_strobe strictly after the commit cycle, and cfg_pending clears on that same edge.
  - In IDLE, the copy happens on the next edge.
  - Shadow writes while pending are allowed; the latest value is applied.
  - Write and commit in the same cycle apply the new value.

## Timing
- clk_out is registered with 1 cycle latency from cnt. ch0 rises in the cycle after cnt=0, provided h0 > 0 and d0 = 0.
- First ch0 rising edge comes 2 edges after enable is sampled high in IDLE: one edge to enter RUN with cnt=0, one to register the output.
- A new config takes effect from the cnt=0 tick of the following period. The old period always completes.
- cfg_rdata updates 1 cycle after cfg_ch changes or after a commit applies.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock.

## Structure
- fw_clkgen_pkg holds:
  - state enum (IDLE, RUN, BURST);
  - ch_cfg_t struct {sign, high, delay};
  - clamp function;
  - MODE_CONT/MODE_BURST constants.
- Sub-module fw_clkgen_phase_ch is instantiated NUM_CH times. It takes cnt, P and ch_cfg_t, and produces the registered output.
- Top level contains the counter, FSM, shadow/active registers, burst counter and readback mux.

## Test plan
- P=10; ch1 d=2, h=5, sign=0 → both periods 25.0 ns; ch1 rising edge 5.0 ns after ch0 rising edge.
- P=40; ch1 d=3, sign=1 → ch1 falling edge 7.5 ns after ch0 rising edge. With d=0, sign=1 → ch1 is the exact inverse of ch0.
- Running at P=10, commit P=20 at cnt=4 → cfg_pending high until the boundary. Every ch0 period is exactly 25 ns or 50 ns; no intermediate period appears.
- run_mode=1, burst_len=3 → exactly 3 ch0 rising edges, burst_done one cycle after the 3rd cycle_strobe, then outputs at 0. A repeat with enable dropped after the 2nd edge gives outputs 0 on the next edge and no burst_done.
- Clamp checks: period=1 → P=2; h=0, sign=0 → constant 0; d=15 with P=10 → readback shows delay 9.
- fw_rst_n pulsed mid-burst between clock edges → outputs 0 immediately; readback equals RST_PERIOD defaults.
